mat_mult_seq: RTL and testbench
===============================

// Module: mat_mult_seq
// PURPOSE
//   Sequenced 2x2 matrix multiplier: C = A x B, with 8-bit unsigned elements and 17-bit results.
//   A single shared multiply-add unit computes a_pq*b_pq + a_rs*b_rs once per cycle.
//   A small FSM steps this unit over the four result elements.
//   Used where the fully parallel four-unit multiplier is too large.
//   Input and output use a valid/ready handshake so it drops into streaming pipelines.
// PARAMETERS
//   DATA_W          8   element width; result width RES_W = 2*DATA_W+1
//   CNT_W           8   width of the completed-operation counter op_cnt
//   CLEAR_ON_START  1   1: zero c_* on accept; 0: c_* keep old values until overwritten
// PORTS
//   clk        in   1         clock; all state updates on posedge
//   rst        in   1         asynchronous, active-high reset
//   in_valid   in   1         a_in/b_in hold a valid operand set
//   in_ready   out  1         block can accept operands (high only in IDLE)
//   a_in       in   4*DATA_W  {a_11,a_12,a_21,a_22}, a_11 in most significant slice
//   b_in       in   4*DATA_W  {b_11,b_12,b_21,b_22}, b_11 in most significant slice
//   out_valid  out  1         c_11..c_22 hold a complete, stable result
//   out_ready  in   1         consumer takes the result
//   c_11..c_22 out  RES_W     registered result elements
//   busy       out  1         state is CALC
//   op_cnt     out  CNT_W     number of completed output handshakes, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately, at any time):
//     state=IDLE, idx=0, operand registers=0, c_*=0, out_valid=0, busy=0, op_cnt=0.
//     in_ready=1 in the first cycle after rst deasserts.
//     An operation in flight is discarded; no partial result is ever flagged valid.
//   FSM states: IDLE -> CALC -> DONE -> IDLE.
//     IDLE: in_ready=1.
//       On in_valid&&in_ready: capture a_in/b_in, idx=0, go to CALC.
//       If CLEAR_ON_START=1, also zero c_* on this edge.
//     CALC: in_ready=0, busy=1. Each edge writes one element, then idx increments:
//       idx0: c_11 = a_11*b_11 + a_12*b_21
//       idx1: c_12 = a_11*b_12 + a_12*b_22
//       idx2: c_21 = a_21*b_11 + a_22*b_21
//       idx3: c_22 = a_21*b_12 + a_22*b_22, then go to DONE and set out_valid=1.
//     DONE: out_valid=1; c_* stable; in_valid ignored.
//       On out_valid&&out_ready: out_valid=0, op_cnt+1, go to IDLE.
//   Latency: out_valid rises on the 4th posedge after the accept edge.
//     Minimum initiation interval is 6 cycles (accept, 4 CALC, handoff).
//     in_ready returns the cycle after the output handshake.
//   Arithmetic: unsigned throughout. Each product is 2*DATA_W bits.
//     The sum is zero-extended to RES_W, so there is never overflow or truncation.
//   Operands are registered at accept. Changes on a_in/b_in after accept do not affect the result.
//   c_* are meaningful only while out_valid=1. After handoff they keep their last value
//     until the next accept (CLEAR_ON_START=1) or the next overwrite (CLEAR_ON_START=0).
//   op_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//   in_valid and out_ready are never both acted on in the same cycle, since in_ready=0 in DONE.
// TESTING
//   1. rst pulse mid-cycle, no clock edge -> out_valid=0, c_*=0, op_cnt=0 at once; in_ready=1 after release.
//   2. A={1,2,3,4}, B=identity {1,0,0,1}, out_ready=1 -> C={1,2,3,4};
//      out_valid exactly 4 edges after accept; op_cnt=1.
//   3. All a=b=255 -> every c = 130050 (0x1FC02), no truncation.
//      A={1,2,3,4}, B={5,6,7,8} -> C={19,22,43,50}.
//   4. out_ready=0 for 10 cycles in DONE, a_in/in_valid toggling -> c_*/out_valid stable, in_ready=0;
//      out_ready=1 -> handoff, IDLE next cycle.
//   5. rst during CALC at idx=2 -> out_valid never asserts for that op;
//      next op A={1,2,3,4}, B={5,6,7,8} yields {19,22,43,50}.
//   6. 256 back-to-back ops with CNT_W=8 -> op_cnt returns to 0; each initiation interval is 6 cycles.

Source files
------------

// File: rtl/mat_mult_seq_if.sv
// Handshake/data bundle for mat_mult_seq.
//   in_valid/in_ready/a_in/b_in : operand stream (a_11 / b_11 in the top slice)
//   out_valid/out_ready/c_*     : result stream, RES_W = 2*DATA_W+1 per element
//   busy                        : multiplier is stepping through the elements
//   op_cnt                      : completed output handshakes, wraps silently
// master = producer/consumer side, slave = the multiplier.
interface mat_mult_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned RES_W = 2*DATA_W + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DATA_W-1:0]   a_in;
  logic [4*DATA_W-1:0]   b_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [RES_W-1:0]      c_11;
  logic [RES_W-1:0]      c_12;
  logic [RES_W-1:0]      c_21;
  logic [RES_W-1:0]      c_22;
  logic                  busy;
  logic [CNT_W-1:0]      op_cnt;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_11, c_12, c_21, c_22, busy, op_cnt
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, c_11, c_12, c_21, c_22, busy, op_cnt
  );
endinterface

// File: rtl/mat_mult_seq.sv
// Sequenced 2x2 unsigned matrix multiplier, C = A x B.
// One shared multiply-add unit (two products + one add) produces one result
// element per cycle; a small FSM walks it over c_11, c_12, c_21, c_22.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - mat_mult_seq_if.slave (operand/result handshakes, busy, op_cnt)
module mat_mult_seq #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned CLEAR_ON_START = 1
) (
  input  logic           clk,
  input  logic           rst,
  mat_mult_seq_if.slave  bus
);
  localparam int unsigned RES_W = 2*DATA_W + 1;
  localparam int unsigned PRD_W = 2*DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          idx;
  logic [4*DATA_W-1:0] a_r, b_r;
  logic [RES_W-1:0]    c_11, c_12, c_21, c_22;
  logic [CNT_W-1:0]    op_cnt;

  logic [DATA_W-1:0]   a_11, a_12, a_21, a_22;
  logic [DATA_W-1:0]   b_11, b_12, b_21, b_22;
  logic [DATA_W-1:0]   m_a0, m_a1, m_b0, m_b1;
  logic [PRD_W-1:0]    prod0, prod1;
  logic [RES_W-1:0]    mac;

  assign a_11 = a_r[4*DATA_W-1 -: DATA_W];
  assign a_12 = a_r[3*DATA_W-1 -: DATA_W];
  assign a_21 = a_r[2*DATA_W-1 -: DATA_W];
  assign a_22 = a_r[DATA_W-1:0];
  assign b_11 = b_r[4*DATA_W-1 -: DATA_W];
  assign b_12 = b_r[3*DATA_W-1 -: DATA_W];
  assign b_21 = b_r[2*DATA_W-1 -: DATA_W];
  assign b_22 = b_r[DATA_W-1:0];

  // idx[1] selects the row of A, idx[0] the column of B:
  // idx 0..3 -> c_11, c_12, c_21, c_22.
  always_comb begin
    m_a0 = idx[1] ? a_21 : a_11;
    m_a1 = idx[1] ? a_22 : a_12;
    m_b0 = idx[0] ? b_12 : b_11;
    m_b1 = idx[0] ? b_22 : b_21;
  end

  // Full-width products and a zero-extended sum: never truncates.
  assign prod0 = PRD_W'(m_a0) * PRD_W'(m_b0);
  assign prod1 = PRD_W'(m_a1) * PRD_W'(m_b1);
  assign mac   = RES_W'(prod0) + RES_W'(prod1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      c_11   <= '0;
      c_12   <= '0;
      c_21   <= '0;
      c_22   <= '0;
      op_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a_in;
            b_r   <= bus.b_in;
            idx   <= '0;
            state <= S_CALC;
            if (CLEAR_ON_START != 0) begin
              c_11 <= '0;
              c_12 <= '0;
              c_21 <= '0;
              c_22 <= '0;
            end
          end
        end
        S_CALC: begin
          case (idx)
            2'd0:    c_11 <= mac;
            2'd1:    c_12 <= mac;
            2'd2:    c_21 <= mac;
            default: c_22 <= mac;
          endcase
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            op_cnt <= op_cnt + CNT_W'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so a reset
  // drops out_valid/busy immediately without needing extra flops.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_CALC);
  assign bus.out_valid = (state == S_DONE);
  assign bus.c_11      = c_11;
  assign bus.c_12      = c_12;
  assign bus.c_21      = c_21;
  assign bus.c_22      = c_22;
  assign bus.op_cnt    = op_cnt;
endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: results are compared against a
// plain row-by-column matrix product computed in the bench.
module tb_mat_mult_seq;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  longint  cyc = 0;
  int      checks = 0;
  int      failures = 0;
  int      exp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_mult_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mat_mult_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CLEAR_ON_START(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // C[i][j] = sum_k A[i][k]*B[k][j]; elements packed row-major, [0][0] on top.
  function automatic logic [67:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    int unsigned am [2][2];
    int unsigned bm [2][2];
    int unsigned s;
    logic [67:0] r;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        am[i][k] = 32'(a[31-8*(2*i+k) -: 8]);
        bm[i][k] = 32'(b[31-8*(2*i+k) -: 8]);
      end
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += am[i][k] * bm[k][j];
        r[67-17*(2*i+j) -: 17] = 17'(s);
      end
    return r;
  endfunction

  function automatic logic [67:0] cur_c();
    return {bus.c_11, bus.c_12, bus.c_21, bus.c_22};
  endfunction

  // Drives one operation starting at a negedge. Returns at a negedge:
  // in IDLE if handoff=1 (out_ready must be 1), otherwise still in DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit handoff,
                        output logic [67:0] c, output logic [67:0] c0,
                        output int lat, output longint acc, output bit to);
    int n;
    to = 1'b0;
    bus.a_in = a;
    bus.b_in = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) to = 1'b1;
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    c0 = cur_c();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) to = 1'b1;
    c = cur_c();
    if (handoff) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [67:0] c, c0;
    int lat;
    longint acc;
    bit to;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_flags got ov=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
    checks++; if (cur_c() !== 68'd0 || bus.op_cnt !== 8'd0) begin failures++; $display("FAIL rst_regs got c=%0h cnt=%0d exp 0", cur_c(), bus.op_cnt); end
    @(negedge clk);
    // Build up nonzero state, then pulse reset between clock edges.
    bus.out_ready = 1'b1;
    run_op(32'h01020304, 32'h05060708, 1'b1, c, c0, lat, acc, to);
    bus.out_ready = 1'b0;
    run_op(32'h0A0B0C0D, 32'h01020304, 1'b0, c, c0, lat, acc, to);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL async_rst_flags got ov=%b busy=%b exp 0/0", bus.out_valid, bus.busy); end
    checks++; if (cur_c() !== 68'd0) begin failures++; $display("FAIL async_rst_c got=%0h exp=0", cur_c()); end
    checks++; if (bus.op_cnt !== 8'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d exp=0", bus.op_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%b exp=1", bus.in_ready); end
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [67:0] c, c0, e;
    int lat;
    longint acc;
    bit to;
    bus.out_ready = 1'b1;
    e = ref_mult(32'h01020304, 32'h01000001);
    run_op(32'h01020304, 32'h01000001, 1'b1, c, c0, lat, acc, to);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++; if (to) begin failures++; $display("FAIL ident_timeout got=timeout exp=done"); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ident_latency got=%0d exp=4", lat); end
    checks++; if (c !== e) begin failures++; $display("FAIL ident_result got=%0h exp=%0h", c, e); end
    checks++; if (bus.op_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL ident_cnt got=%0d exp=%0d", bus.op_cnt, exp_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ident_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_arith();
    logic [67:0] c, c0, e;
    int lat;
    longint acc;
    bit to;
    bus.out_ready = 1'b1;
    e = ref_mult(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, c, c0, lat, acc, to);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++; if (to || c !== e) begin failures++; $display("FAIL max_result got=%0h exp=%0h to=%b", c, e, to); end
    e = ref_mult(32'h01020304, 32'h05060708);
    run_op(32'h01020304, 32'h05060708, 1'b1, c, c0, lat, acc, to);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++; if (c0 !== 68'd0) begin failures++; $display("FAIL clear_on_start got=%0h exp=0", c0); end
    checks++; if (to || c !== e) begin failures++; $display("FAIL known_result got=%0h exp=%0h to=%b", c, e, to); end
    checks++; if (bus.op_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL arith_cnt got=%0d exp=%0d", bus.op_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [67:0] c, c0, e;
    int lat;
    longint acc;
    bit to;
    logic [31:0] a, b;
    int bad;
    a = $urandom;
    b = $urandom;
    e = ref_mult(a, b);
    bus.out_ready = 1'b0;
    run_op(a, b, 1'b0, c, c0, lat, acc, to);
    checks++; if (to || c !== e) begin failures++; $display("FAIL stall_result got=%0h exp=%0h to=%b", c, e, to); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.a_in = $urandom;
      bus.b_in = $urandom;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || cur_c() !== e) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_handoff got ov=%b ir=%b exp 0/1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.op_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.op_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_calc();
    logic [67:0] c, c0, e;
    int lat;
    longint acc;
    bit to;
    int seen;
    bus.out_ready = 1'b1;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midcalc_busy got=%b exp=1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midcalc_rst got busy=%b ov=%b exp 0/0", bus.busy, bus.out_valid); end
    rst = 1'b0;
    exp_cnt = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midcalc_no_valid got=%0d cycles exp=0", seen); end
    e = ref_mult(32'h01020304, 32'h05060708);
    run_op(32'h01020304, 32'h05060708, 1'b1, c, c0, lat, acc, to);
    exp_cnt = (exp_cnt + 1) % 256;
    checks++; if (to || c !== e) begin failures++; $display("FAIL midcalc_next got=%0h exp=%0h to=%b", c, e, to); end
    checks++; if (bus.op_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL midcalc_cnt got=%0d exp=%0d", bus.op_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [67:0] c, c0, e;
    int lat;
    longint acc, prev;
    bit to;
    logic [31:0] a, b;
    int start;
    bus.out_ready = 1'b1;
    start = exp_cnt;
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 16 == 0) a = '0;
      if (i % 16 == 1) b = '1;
      e = ref_mult(a, b);
      run_op(a, b, 1'b1, c, c0, lat, acc, to);
      exp_cnt = (exp_cnt + 1) % 256;
      checks++; if (to || c !== e) begin failures++; $display("FAIL b2b_result[%0d] got=%0h exp=%0h to=%b", i, c, e, to); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=4", i, lat); end
      if (i > 0) begin
        checks++; if (acc - prev != 6) begin failures++; $display("FAIL b2b_interval[%0d] got=%0d exp=6", i, acc - prev); end
      end
      checks++; if (bus.op_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, bus.op_cnt, exp_cnt); end
      prev = acc;
    end
    checks++; if (bus.op_cnt !== 8'(start)) begin failures++; $display("FAIL b2b_wrap got=%0d exp=%0d", bus.op_cnt, start); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_arith();
    test_stall();
    test_reset_mid_calc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
